// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
//   Raster timing generator for a parallel-RGB LCD panel (default geometry:
//   480x272 panel on a 9 MHz pixel clock). A horizontal pixel counter and a
//   vertical line counter sweep the full frame, including the blanking
//   regions. Every output is a registered decode of those counters, so all
//   outputs share one cycle of latency and stay mutually aligned.
//
// Ports
//   clk9MHz     in   pixel clock; all state changes on the rising edge
//   resetN      in   asynchronous active-low reset
//   run         in   timing enable; low holds the counters at the origin
//   hSync       out  horizontal sync (polarity set by HSYNC_ACT_LOW)
//   vSync       out  vertical sync (polarity set by VSYNC_ACT_LOW)
//   disp        out  panel display-on (registered run)
//   dataEnable  out  high inside the active pixel region
//   pixelX      out  horizontal position, aligned with dataEnable
//   lineY       out  vertical position, aligned with dataEnable
//   frameStart  out  one-cycle pulse at pixel (0,0)
//   userTick    out  one-cycle pulse every TICK_FRAMES frames, riding on
//                    frameStart; never on the first frame after run rises
module lcd_timing_gen #(
    parameter int H_ACTIVE      = 480,
    parameter int H_FRONT       = 2,
    parameter int H_SYNC        = 41,
    parameter int H_BACK        = 2,
    parameter int V_ACTIVE      = 272,
    parameter int V_FRONT       = 2,
    parameter int V_SYNC        = 10,
    parameter int V_BACK        = 2,
    parameter bit HSYNC_ACT_LOW = 1'b1,
    parameter bit VSYNC_ACT_LOW = 1'b1,
    parameter int TICK_FRAMES   = 3,
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk9MHz,
    input  logic          resetN,
    input  logic          run,
    output logic          hSync,
    output logic          vSync,
    output logic          disp,
    output logic          dataEnable,
    output logic [XW-1:0] pixelX,
    output logic [YW-1:0] lineY,
    output logic          frameStart,
    output logic          userTick
);

    // Frame counter width; a single-frame period still needs one bit.
    localparam int FW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

    // Region boundaries at counter width. Sync windows are half-open
    // [start, end); end never exceeds TOTAL-1 because every back porch is >=1.
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FRONT);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FRONT);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [FW-1:0] F_LAST   = FW'(TICK_FRAMES - 1);

    logic [XW-1:0] hCount;
    logic [YW-1:0] vCount;
    logic [FW-1:0] frameCnt;
    // Set when the frame counter wraps to 0; consumed by the next frameStart.
    // This separates "frame counter is 0 after a wrap" from "frame counter
    // is 0 because run just rose", which must not tick.
    logic          tickPend;

    logic hLast, vLast, atOrigin;
    logic deNext, hsAct, vsAct, fsNext, tickNext;

    // ------------------------------------------------------------------
    // Counter decode
    // ------------------------------------------------------------------
    always_comb begin
        hLast    = (hCount == H_LAST);
        vLast    = (vCount == V_LAST);
        atOrigin = (hCount == '0) && (vCount == '0);
        // All qualified by run so that the first cycle after run falls
        // already shows idle syncs and strobes.
        deNext   = run && (hCount < H_ACT_C) && (vCount < V_ACT_C);
        hsAct    = run && (hCount >= HS_START) && (hCount < HS_END);
        vsAct    = run && (vCount >= VS_START) && (vCount < VS_END);
        fsNext   = run && atOrigin;
        tickNext = fsNext && tickPend;
    end

    // ------------------------------------------------------------------
    // Position counters and frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk9MHz or negedge resetN) begin
        if (!resetN) begin
            hCount   <= '0;
            vCount   <= '0;
            frameCnt <= '0;
        end else if (!run) begin
            hCount   <= '0;
            vCount   <= '0;
            frameCnt <= '0;
        end else if (hLast) begin
            hCount <= '0;
            if (vLast) begin
                vCount   <= '0;
                frameCnt <= (frameCnt == F_LAST) ? '0 : frameCnt + 1'b1;
            end else begin
                vCount <= vCount + 1'b1;
            end
        end else begin
            hCount <= hCount + 1'b1;
        end
    end

    always_ff @(posedge clk9MHz or negedge resetN) begin
        if (!resetN) begin
            tickPend <= 1'b0;
        end else if (!run) begin
            tickPend <= 1'b0;
        end else if (hLast && vLast && (frameCnt == F_LAST)) begin
            tickPend <= 1'b1;
        end else if (atOrigin) begin
            tickPend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs: one cycle behind the counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk9MHz or negedge resetN) begin
        if (!resetN) begin
            hSync      <= HSYNC_ACT_LOW;
            vSync      <= VSYNC_ACT_LOW;
            disp       <= 1'b0;
            dataEnable <= 1'b0;
            pixelX     <= '0;
            lineY      <= '0;
            frameStart <= 1'b0;
            userTick   <= 1'b0;
        end else begin
            // XOR with the polarity bit maps "in sync window" to the pin level.
            hSync      <= hsAct ^ HSYNC_ACT_LOW;
            vSync      <= vsAct ^ VSYNC_ACT_LOW;
            disp       <= run;
            dataEnable <= deNext;
            // Position follows the counters ungated: on the edge where run
            // falls it still shows the last counted position, then 0.
            pixelX     <= hCount;
            lineY      <= vCount;
            frameStart <= fsNext;
            userTick   <= tickNext;
        end
    end

endmodule
